// File: rtl/delay_pkg.sv
// Shared definitions for the periodic delay-tick interface: monitor states,
// default generator terminal count and the tick spacing helper.
package delay_pkg;

  typedef enum logic {
    ACQUIRE,
    TRACK
  } state_t;

  localparam int DEFAULT_N     = 22500;
  localparam int DEFAULT_CBITS = 15;

  function automatic int period(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/delay_monitor.sv
// Receiving end of the delay-tick interface: verifies ticks arrive every N+1
// cycles, flags early and late ticks, and declares lock after a run of good ones.
module delay_monitor
  import delay_pkg::*;
#(
  parameter int N          = DEFAULT_N,
  parameter int CBITS      = DEFAULT_CBITS,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig,
  output logic             locked,
  output logic             err_early,
  output logic             err_late,
  output logic             fault,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CBITS-1:0] phase
);

  localparam logic [CBITS-1:0] LAST_PHASE  = CBITS'(N);
  localparam logic [7:0]       LOCK_TARGET = 8'(LOCK_COUNT);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_t     state;
  logic [7:0] good_run;
  logic       early_hit;
  logic       late_hit;
  logic       good_hit;

  assign early_hit = (state == TRACK) && sig && (phase != LAST_PHASE);
  assign late_hit  = (state == TRACK) && !sig && (phase == LAST_PHASE);
  assign good_hit  = (state == TRACK) && sig && (phase == LAST_PHASE);

  // An early tick is discarded rather than used to resync; the next tick seen
  // in ACQUIRE becomes the new reference point.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACQUIRE;
      phase     <= '0;
      good_run  <= '0;
      locked    <= 1'b0;
      err_early <= 1'b0;
      err_late  <= 1'b0;
      fault     <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_early <= early_hit;
      err_late  <= late_hit;
      if (early_hit || late_hit) begin
        state    <= ACQUIRE;
        phase    <= '0;
        good_run <= '0;
        locked   <= 1'b0;
        fault    <= 1'b1;
        if (err_cnt != ERR_MAX) begin
          err_cnt <= err_cnt + ERR_W'(1);
        end
      end else if (state == ACQUIRE) begin
        phase <= '0;
        if (sig) begin
          state    <= TRACK;
          good_run <= '0;
        end
      end else if (good_hit) begin
        phase <= '0;
        if (good_run < LOCK_TARGET) begin
          good_run <= good_run + 8'd1;
        end
        if (good_run >= LOCK_TARGET - 8'd1) begin
          locked <= 1'b1;
        end
      end else begin
        phase <= phase + CBITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_delay_monitor.sv
// Scoreboard bench for delay_monitor: directed tick patterns plus randomized
// generator-like traffic, checked against a tick-time reference model.
module tb_delay_monitor;
  import delay_pkg::*;

  localparam int N          = 4;
  localparam int CBITS      = 4;
  localparam int LOCK_COUNT = 2;
  localparam int ERR_W      = 4;
  localparam int ERR_MAX    = (1 << ERR_W) - 1;

  logic             clk;
  logic             rst;
  logic             sig;
  logic             locked;
  logic             err_early;
  logic             err_late;
  logic             fault;
  logic [ERR_W-1:0] err_cnt;
  logic [CBITS-1:0] phase;

  delay_monitor #(
    .N(N),
    .CBITS(CBITS),
    .LOCK_COUNT(LOCK_COUNT),
    .ERR_W(ERR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sig(sig),
    .locked(locked),
    .err_early(err_early),
    .err_late(err_late),
    .fault(fault),
    .err_cnt(err_cnt),
    .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int locked;
    int early;
    int late;
    int fault;
    int cnt;
    int phase;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: remembers the cycle of the last accepted tick and
  // derives the expected slot and phase from it arithmetically.
  int   cyc = 0;
  bit   m_tracking = 0;
  int   m_last = 0;
  int   m_good = 0;
  int   m_locked = 0;
  int   m_fault = 0;
  int   m_cnt = 0;

  task automatic check_output(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic model_step(input logic s, input logic r);
    exp_t e;
    int   early = 0;
    int   late = 0;
    if (r) begin
      m_tracking = 0;
      m_good     = 0;
      m_locked   = 0;
      m_fault    = 0;
      m_cnt      = 0;
    end else begin
      if (!m_tracking) begin
        if (s) begin
          m_tracking = 1;
          m_last     = cyc;
          m_good     = 0;
        end
      end else if (cyc == m_last + period(N)) begin
        if (s) begin
          m_last = cyc;
          if (m_good < LOCK_COUNT) m_good++;
          if (m_good == LOCK_COUNT) m_locked = 1;
        end else begin
          late = 1;
        end
      end else if (s) begin
        early = 1;
      end
      if (early || late) begin
        m_tracking = 0;
        m_good     = 0;
        m_locked   = 0;
        m_fault    = 1;
        if (m_cnt < ERR_MAX) m_cnt++;
      end
    end
    e.locked = m_locked;
    e.early  = early;
    e.late   = late;
    e.fault  = m_fault;
    e.cnt    = m_cnt;
    e.phase  = m_tracking ? (cyc - m_last) : 0;
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic apply_stimulus(input logic s, input logic r);
    @(negedge clk);
    sig = s;
    rst = r;
    model_step(s, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0);
  endtask

  task automatic ticks_every(input int count, input int spacing);
    for (int i = 0; i < count; i++) begin
      apply_stimulus(1'b1, 1'b0);
      idle(spacing - 1);
    end
  endtask

  // Monitor: the DUT presents a registered result every cycle, so pop one
  // expectation shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("locked", int'(locked), e.locked);
        check_output("err_early", int'(err_early), e.early);
        check_output("err_late", int'(err_late), e.late);
        check_output("fault", int'(fault), e.fault);
        check_output("err_cnt", int'(err_cnt), e.cnt);
        check_output("phase", int'(phase), e.phase);
      end
    end
  end

  initial begin
    int gen_count;
    sig = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1);

    // Correctly spaced ticks, then a lost tick
    ticks_every(5, period(N));
    idle(12);

    // Early tick, then recovery on a later tick
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0);
    idle(2);
    apply_stimulus(1'b1, 1'b0);
    idle(2);
    ticks_every(4, period(N));
    idle(8);

    // Repeated early ticks drive err_cnt into saturation
    ticks_every(90, 2);
    apply_stimulus(1'b0, 1'b1);
    idle(2);

    // Reset in the middle of good tracking, with a tick in the reset cycle
    ticks_every(1, period(N));
    idle(2);
    apply_stimulus(1'b1, 1'b1);
    idle(1);
    ticks_every(4, period(N));

    // Generator-like traffic with occasional glitches and resets
    gen_count = 0;
    for (int i = 0; i < 3000; i++) begin
      logic s;
      logic r;
      s = (gen_count == N);
      if ($urandom_range(0, 99) < 3) s = ~s;
      r = ($urandom_range(0, 399) == 0);
      apply_stimulus(s, r);
      gen_count = (gen_count == N) ? 0 : gen_count + 1;
    end

    // Clean generator run: lock must be reached and held without errors
    apply_stimulus(1'b0, 1'b1);
    gen_count = 0;
    for (int i = 0; i < 200; i++) begin
      apply_stimulus(gen_count == 0, 1'b0);
      gen_count = (gen_count == N) ? 0 : gen_count + 1;
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
